// File: rtl/gamepad_pkg.sv
// Shared types and cycle-count helpers for the gamepad scanner.
package gamepad_pkg;
   localparam int NES_BITS  = 8;
   localparam int SNES_BITS = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCH,
      ST_CLK_LOW,
      ST_CLK_HIGH,
      ST_DONE
   } state_e;

   function automatic int us_to_cyc(input int clk_hz, input int us);
      return clk_hz / 1000000 * us;
   endfunction

   function automatic int hz_to_cyc(input int clk_hz, input int hz);
      return clk_hz / hz;
   endfunction
endpackage

// File: rtl/gamepad_scanner_if.sv
// Host-side and pad-side signals of the gamepad scanner.
interface gamepad_scanner_if #(
   parameter int NUM_PADS = 2,
   parameter int NUM_BITS = 8
);
   logic                         i_enable;
   logic                         i_poll_req;
   logic [NUM_PADS-1:0]          i_serial_data;
   logic                         o_data_latch;
   logic                         o_data_clock;
   logic [NUM_PADS*NUM_BITS-1:0] o_buttons;
   logic                         o_valid;
   logic [NUM_PADS-1:0]          o_changed;
   logic                         o_busy;

   modport master (
      output i_enable, i_poll_req, i_serial_data,
      input  o_data_latch, o_data_clock, o_buttons, o_valid, o_changed, o_busy
   );

   modport slave (
      input  i_enable, i_poll_req, i_serial_data,
      output o_data_latch, o_data_clock, o_buttons, o_valid, o_changed, o_busy
   );
endinterface

// File: rtl/gamepad_timer.sv
// Loadable down-counter; o_zero flags the last cycle of a timed phase.
module gamepad_timer #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_value,
   output logic         o_zero
);
   logic [W-1:0] cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst)            cnt <= '0;
      else if (i_load)      cnt <= i_value;
      else if (cnt != '0)   cnt <= cnt - 1'b1;
   end

   assign o_zero = (cnt == '0);
endmodule

// File: rtl/gamepad_scanner.sv
// NES/SNES-style pad scanner: latch pulse, shared shift clock, per-pad
// sampling, snapshot with per-pad change flags.
module gamepad_scanner
   import gamepad_pkg::*;
#(
   parameter int CLK_HZ      = 27000000,
   parameter int POLL_HZ     = 120,
   parameter int LATCH_US    = 12,
   parameter int HALF_BIT_US = 6,
   parameter int NUM_PADS    = 2,
   parameter int NUM_BITS    = NES_BITS
) (
   input logic              i_clk,
   input logic              i_rst,
   gamepad_scanner_if.slave bus
);
   localparam int LATCH_CYC = us_to_cyc(CLK_HZ, LATCH_US);
   localparam int HALF_CYC  = us_to_cyc(CLK_HZ, HALF_BIT_US);
   localparam int POLL_CYC  = hz_to_cyc(CLK_HZ, POLL_HZ);
   localparam int TMAX      = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
   localparam int TW        = $clog2(TMAX + 1);
   localparam int PW        = $clog2(POLL_CYC + 1);
   localparam int IW        = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

   if (LATCH_CYC < 1 || HALF_CYC < 1 || POLL_CYC < 1) begin : g_bad_timing
      $error("gamepad_scanner: derived cycle counts must all be >= 1");
   end
   if (NUM_PADS < 1 || NUM_PADS > 4) begin : g_bad_pads
      $error("gamepad_scanner: NUM_PADS must be 1..4");
   end

   state_e                             state;
   logic [IW-1:0]                      bit_idx;
   logic                               pending;
   logic [PW-1:0]                      poll_cnt;
   logic                               poll_exp;
   logic                               start_req;
   logic                               last_bit;
   logic [NUM_PADS-1:0][NUM_BITS-1:0]  samp, samp_nxt, btn_nxt;
   logic                               tmr_load, tmr_zero;
   logic [TW-1:0]                      tmr_val;

   // Free-running poll timer; disabling holds it at zero.
   always_ff @(posedge i_clk) begin
      if (i_rst || !bus.i_enable) poll_cnt <= '0;
      else if (poll_exp)          poll_cnt <= '0;
      else                        poll_cnt <= poll_cnt + 1'b1;
   end

   assign poll_exp  = bus.i_enable && (poll_cnt == PW'(POLL_CYC - 1));
   assign start_req = pending || bus.i_poll_req || poll_exp;
   assign last_bit  = (bit_idx == IW'(NUM_BITS - 1));

   // Reload the phase timer on every transition into a timed state.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = TW'(HALF_CYC - 1);
      case (state)
         ST_IDLE, ST_DONE: if (start_req) begin
            tmr_load = 1'b1;
            tmr_val  = TW'(LATCH_CYC - 1);
         end
         ST_LATCH, ST_CLK_HIGH: tmr_load = tmr_zero;
         ST_CLK_LOW:            tmr_load = tmr_zero && !last_bit;
         default:               tmr_load = 1'b0;
      endcase
   end

   gamepad_timer #(.W(TW)) u_timer (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (tmr_load),
      .i_value (tmr_val),
      .o_zero  (tmr_zero)
   );

   // Merge the current serial bits so the final sample lands in the snapshot.
   always_comb begin
      samp_nxt = samp;
      for (int p = 0; p < NUM_PADS; p++) samp_nxt[p][bit_idx] = bus.i_serial_data[p];
   end
   assign btn_nxt = ~samp_nxt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state            <= ST_IDLE;
         bit_idx          <= '0;
         pending          <= 1'b0;
         samp             <= '0;
         bus.o_data_latch <= 1'b0;
         bus.o_data_clock <= 1'b0;
         bus.o_buttons    <= '0;
         bus.o_valid      <= 1'b0;
         bus.o_changed    <= '0;
         bus.o_busy       <= 1'b0;
      end else begin
         bus.o_valid   <= 1'b0;
         bus.o_changed <= '0;
         if (state != ST_IDLE && state != ST_DONE && (bus.i_poll_req || poll_exp))
            pending <= 1'b1;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start_req) begin
                  state            <= ST_LATCH;
                  pending          <= 1'b0;
                  bus.o_data_latch <= 1'b1;
                  bus.o_busy       <= 1'b1;
               end else begin
                  state      <= ST_IDLE;
                  bus.o_busy <= 1'b0;
               end
            end
            ST_LATCH: if (tmr_zero) begin
               state            <= ST_CLK_LOW;
               bit_idx          <= '0;
               bus.o_data_latch <= 1'b0;
            end
            ST_CLK_LOW: if (tmr_zero) begin
               samp <= samp_nxt;
               if (last_bit) begin
                  state         <= ST_DONE;
                  bus.o_buttons <= btn_nxt;
                  bus.o_valid   <= 1'b1;
                  for (int p = 0; p < NUM_PADS; p++)
                     bus.o_changed[p] <= (btn_nxt[p] != bus.o_buttons[p*NUM_BITS +: NUM_BITS]);
               end else begin
                  state            <= ST_CLK_HIGH;
                  bus.o_data_clock <= 1'b1;
               end
            end
            ST_CLK_HIGH: if (tmr_zero) begin
               state            <= ST_CLK_LOW;
               bit_idx          <= bit_idx + 1'b1;
               bus.o_data_clock <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gamepad_scanner.sv
// Directed bench: behavioural pads, scoreboard of expected snapshots.
module tb_gamepad_scanner;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gamepad_scanner_if #(.NUM_PADS(2), .NUM_BITS(8))  if_a ();
   gamepad_scanner_if #(.NUM_PADS(2), .NUM_BITS(16)) if_b ();

   gamepad_scanner #(.CLK_HZ(1000000), .POLL_HZ(1000), .LATCH_US(12), .HALF_BIT_US(6),
                     .NUM_PADS(2), .NUM_BITS(8)) dut_a (
      .i_clk (clk), .i_rst (rst), .bus (if_a.slave));

   gamepad_scanner #(.CLK_HZ(1000000), .POLL_HZ(1000), .LATCH_US(12), .HALF_BIT_US(6),
                     .NUM_PADS(2), .NUM_BITS(16)) dut_b (
      .i_clk (clk), .i_rst (rst), .bus (if_b.slave));

   typedef struct { logic [15:0] btn; logic [1:0] chg; } exp_t;
   exp_t sb[$];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pads: latch reloads, each rising shift clock advances to the next bit.
   logic [1:0][7:0]  press_a = '0;
   logic [1:0][15:0] press_b = '0;
   logic [2:0] ptr_a = '0;
   logic [3:0] ptr_b = '0;
   logic pclk_a = 1'b0, pclk_b = 1'b0;

   always @(posedge clk) begin
      pclk_a <= if_a.o_data_clock;
      pclk_b <= if_b.o_data_clock;
      if (if_a.o_data_latch) ptr_a <= '0;
      else if (if_a.o_data_clock && !pclk_a) ptr_a <= ptr_a + 3'd1;
      if (if_b.o_data_latch) ptr_b <= '0;
      else if (if_b.o_data_clock && !pclk_b) ptr_b <= ptr_b + 4'd1;
   end

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         if_a.i_serial_data[p] = ~press_a[p][ptr_a];
         if_b.i_serial_data[p] = ~press_b[p][ptr_b];
      end
   end

   // Monitor for the 8-bit instance: phase shape and scoreboard pop on o_valid.
   int cyc = 0, n_valid = 0, latch_cnt = 0, rises = 0, scan_len = 0;
   int vstamp[$];
   logic lat_d = 1'b0, clk_d = 1'b0, val_d = 1'b0, overlap = 1'b0, dbl_valid = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (if_a.o_data_latch && if_a.o_data_clock) overlap = 1'b1;
      if (if_a.o_valid && val_d) dbl_valid = 1'b1;
      if (if_a.o_data_latch && !lat_d) begin
         latch_cnt = 1; rises = 0; scan_len = 0;
      end else begin
         scan_len++;
         if (if_a.o_data_latch) latch_cnt++;
      end
      if (if_a.o_data_clock && !clk_d) rises++;
      lat_d = if_a.o_data_latch;
      clk_d = if_a.o_data_clock;
      val_d = if_a.o_valid;
      if (if_a.o_valid) begin
         n_valid++;
         vstamp.push_back(cyc);
         chk("latch_width", 32'(latch_cnt), 32'd12);
         chk("clk_pulses", 32'(rises), 32'd7);
         chk("scan_len", 32'(scan_len), 32'd102);
         chk("latch_clk_overlap", 32'(overlap), 32'd0);
         chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("buttons", 32'(if_a.o_buttons), 32'(e.btn));
            chk("changed", 32'(if_a.o_changed), 32'(e.chg));
         end
      end
   end

   int n_valid_b = 0, rises_b = 0, rises_b_seen = 0;
   logic clk_db = 1'b0;
   logic [1:0] chg_b_seen = '0;
   always @(negedge clk) begin
      if (if_b.o_data_latch) rises_b = 0;
      if (if_b.o_data_clock && !clk_db) rises_b++;
      clk_db = if_b.o_data_clock;
      if (if_b.o_valid) begin
         n_valid_b++;
         rises_b_seen = rises_b;
         chg_b_seen   = if_b.o_changed;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic pulse_req();
      if_a.i_poll_req = 1'b1;
      tick();
      if_a.i_poll_req = 1'b0;
   endtask

   task automatic wait_valid(input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (n_valid >= target) break;
         tick();
      end
      chk("valid_timeout", 32'(n_valid >= target), 32'd1);
   endtask

   task automatic push(input logic [15:0] b, input logic [1:0] c);
      exp_t e;
      e.btn = b; e.chg = c;
      sb.push_back(e);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      if_a.i_enable = 1'b0; if_a.i_poll_req = 1'b0;
      if_b.i_enable = 1'b0; if_b.i_poll_req = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_latch",   32'(if_a.o_data_latch), 32'd0);
      chk("rst_clock",   32'(if_a.o_data_clock), 32'd0);
      chk("rst_buttons", 32'(if_a.o_buttons),    32'd0);
      chk("rst_valid",   32'(if_a.o_valid),      32'd0);
      chk("rst_changed", 32'(if_a.o_changed),    32'd0);
      chk("rst_busy",    32'(if_a.o_busy),       32'd0);

      // Pad0 presses A only.
      press_a[0] = 8'h01; press_a[1] = 8'h00;
      push(16'h0001, 2'b01);
      pulse_req();
      chk("req_latch_next", 32'(if_a.o_data_latch), 32'd1);
      chk("req_busy",       32'(if_a.o_busy),       32'd1);
      wait_valid(1, 300);
      chk("valid_one_cycle", 32'(if_a.o_valid), 32'd0);

      // Same buttons again: no change flags.
      push(16'h0001, 2'b00);
      pulse_req();
      wait_valid(2, 300);

      // Both pads change.
      press_a[0] = 8'h00; press_a[1] = 8'h84;
      push(16'h8400, 2'b11);
      pulse_req();
      wait_valid(3, 300);
      repeat (5) tick();

      // Requests during a scan collapse into one back-to-back scan.
      push(16'h8400, 2'b00);
      push(16'h8400, 2'b00);
      n0 = n_valid;
      pulse_req();
      repeat (3) begin
         repeat (20) tick();
         pulse_req();
      end
      wait_valid(n0 + 1, 300);
      chk("extra_scan_start", 32'(if_a.o_data_latch), 32'd1);
      wait_valid(n0 + 2, 300);
      repeat (300) tick();
      chk("extra_scan_count", 32'(n_valid - n0), 32'd2);

      // Automatic polling period.
      repeat (3) push(16'h8400, 2'b00);
      n0 = n_valid;
      if_a.i_enable = 1'b1;
      wait_valid(n0 + 3, 3500);
      chk("poll_period_1", 32'(vstamp[n0 + 1] - vstamp[n0]),     32'd1000);
      chk("poll_period_2", 32'(vstamp[n0 + 2] - vstamp[n0 + 1]), 32'd1000);

      // Disable mid-scan: scan completes, no further polls.
      push(16'h8400, 2'b00);
      for (int i = 0; i < 1100; i++) begin
         if (if_a.o_busy) break;
         tick();
      end
      chk("poll_busy_seen", 32'(if_a.o_busy), 32'd1);
      repeat (10) tick();
      if_a.i_enable = 1'b0;
      wait_valid(n0 + 4, 300);
      repeat (2500) tick();
      chk("no_poll_after_disable", 32'(n_valid - n0), 32'd4);

      // Reset during CLK_HIGH of bit 3.
      n0 = n_valid;
      pulse_req();
      for (int i = 0; i < 200; i++) begin
         if (rises == 4 && if_a.o_data_clock) break;
         tick();
      end
      chk("in_clk_high_bit3", 32'(if_a.o_data_clock), 32'd1);
      rst = 1'b1;
      tick();
      chk("abort_latch",   32'(if_a.o_data_latch), 32'd0);
      chk("abort_clock",   32'(if_a.o_data_clock), 32'd0);
      chk("abort_busy",    32'(if_a.o_busy),       32'd0);
      chk("abort_buttons", 32'(if_a.o_buttons),    32'd0);
      chk("abort_valid",   32'(if_a.o_valid),      32'd0);
      tick();
      rst = 1'b0;
      repeat (200) tick();
      chk("abort_no_valid", 32'(n_valid - n0), 32'd0);

      // All of pad0 pressed, snapshot history cleared by reset.
      press_a[0] = 8'hFF; press_a[1] = 8'h00;
      push(16'h00FF, 2'b01);
      pulse_req();
      wait_valid(n0 + 1, 300);

      // 16-bit pads: pad1 presses bits 4 and 15.
      press_b[0] = 16'h0000; press_b[1] = 16'h8010;
      if_b.i_poll_req = 1'b1;
      tick();
      if_b.i_poll_req = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (n_valid_b != 0) break;
         tick();
      end
      chk("snes_valid",   32'(n_valid_b),      32'd1);
      chk("snes_buttons", if_b.o_buttons,      32'h8010_0000);
      chk("snes_changed", 32'(chg_b_seen),     32'd2);
      chk("snes_pulses",  32'(rises_b_seen),   32'd15);

      repeat (5) tick();
      chk("sb_drained",   32'(sb.size()), 32'd0);
      chk("valid_single", 32'(dbl_valid), 32'd0);
      chk("overlap_any",  32'(overlap),   32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
